// File: rtl/crono_ctrl.sv
// crono_ctrl: stopwatch sequencer (button edits, 1 Hz carry burst, shared clear).
// Optional up/down auto-repeat is built only when CRONO_AUTOREPEAT_EN is defined.
module crono_ctrl #(
  parameter int REP_DELAY  = 50_000_000,
  parameter int REP_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_field,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       tick_1hz,
  input  logic [5:0] seg_val,
  input  logic [5:0] min_val,
  input  logic [4:0] hr_val,
  output logic [1:0] en,
  output logic       aumento,
  output logic       disminuye,
  output logic       clr_cnt,
  output logic       running,
  output logic       full
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_INC_SEG, S_INC_MIN, S_INC_HR, S_FULL
  } state_t;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_MIN  = 2'd1;
  localparam logic [1:0] F_SEG  = 2'd2;
  localparam logic [1:0] F_HR   = 2'd3;

  state_t     state, state_nx;
  logic [1:0] sel, sel_nx;
  logic       c_min, c_hr, c_min_nx, c_hr_nx;

  // Inputs are sampled once, then edge-detected against the previous sample.
  logic       field_q, up_q, down_q, start_q, clear_q, tick_q;
  logic       field_p, up_p, down_p, start_p, clear_p;
  logic [5:0] seg_q, min_q;
  logic [4:0] hr_q;
  logic       field_e, up_e, down_e, start_e, clear_e;
  logic       at_max;

  logic [1:0] en_nx;
  logic       aumento_nx, disminuye_nx, clr_nx, running_nx, full_nx;
  logic       up_hit, dn_hit;

`ifdef CRONO_AUTOREPEAT_EN
  localparam int CW = $clog2(REP_DELAY + 1);
  logic [CW-1:0] rep_cnt, rep_nx;
`else
  logic unused_params;
  assign unused_params = ^{32'(REP_DELAY), 32'(REP_PERIOD)};
`endif

  assign field_e = field_q & ~field_p;
  assign up_e    = up_q    & ~up_p;
  assign down_e  = down_q  & ~down_p;
  assign start_e = start_q & ~start_p;
  assign clear_e = clear_q & ~clear_p;
  assign at_max  = (hr_q == 5'd23) && (min_q == 6'd59) && (seg_q == 6'd59);

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    c_min_nx = c_min;
    c_hr_nx  = c_hr;
    up_hit   = 1'b0;
    dn_hit   = 1'b0;
    clr_nx   = 1'b0;
`ifdef CRONO_AUTOREPEAT_EN
    rep_nx   = '0;
`endif
    case (state)
      S_IDLE: begin
        if (start_e) begin
          state_nx = S_RUN;
        end else if (field_e) begin
          case (sel)
            F_SEG:   sel_nx = F_MIN;
            F_MIN:   sel_nx = F_HR;
            default: sel_nx = F_SEG;
          endcase
        end else begin
          up_hit = up_e & ~down_e;
          dn_hit = down_e & ~up_e;
`ifdef CRONO_AUTOREPEAT_EN
          if (up_e || down_e) begin
            rep_nx = (up_e ^ down_e) ? CW'(1) : '0;
          end else if ((up_q ^ down_q) && (rep_cnt != '0)) begin
            // Reload so the next hit lands REP_PERIOD cycles later.
            if (rep_cnt == CW'(REP_DELAY)) begin
              up_hit = up_q;
              dn_hit = down_q;
              rep_nx = CW'(REP_DELAY - REP_PERIOD + 1);
            end else begin
              rep_nx = rep_cnt + CW'(1);
            end
          end
`endif
        end
      end
      S_RUN: begin
        if (start_e) begin
          state_nx = S_IDLE;
        end else if (tick_q) begin
          if (at_max) begin
            state_nx = S_FULL;
          end else begin
            state_nx = S_INC_SEG;
            c_min_nx = (seg_q == 6'd59);
            c_hr_nx  = (seg_q == 6'd59) && (min_q == 6'd59);
          end
        end
      end
      S_INC_SEG: state_nx = c_min ? S_INC_MIN : S_RUN;
      S_INC_MIN: state_nx = c_hr ? S_INC_HR : S_RUN;
      S_INC_HR:  state_nx = S_RUN;
      S_FULL:    state_nx = S_FULL;
      default:   state_nx = S_IDLE;
    endcase

    if (clear_e) begin
      state_nx = S_IDLE;
      sel_nx   = F_SEG;
      up_hit   = 1'b0;
      dn_hit   = 1'b0;
      clr_nx   = 1'b1;
`ifdef CRONO_AUTOREPEAT_EN
      rep_nx   = '0;
`endif
    end

    // Outputs are derived from the state being entered, then registered.
    case (state_nx)
      S_IDLE:    en_nx = sel_nx;
      S_INC_SEG: en_nx = F_SEG;
      S_INC_MIN: en_nx = F_MIN;
      S_INC_HR:  en_nx = F_HR;
      default:   en_nx = F_NONE;
    endcase
    aumento_nx   = up_hit || (state_nx == S_INC_SEG) || (state_nx == S_INC_MIN) ||
                   (state_nx == S_INC_HR);
    disminuye_nx = dn_hit;
    running_nx   = (state_nx == S_RUN) || (state_nx == S_INC_SEG) ||
                   (state_nx == S_INC_MIN) || (state_nx == S_INC_HR);
    full_nx      = (state_nx == S_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      sel       <= F_SEG;
      c_min     <= 1'b0;
      c_hr      <= 1'b0;
      field_q   <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      start_q   <= 1'b0;
      clear_q   <= 1'b0;
      tick_q    <= 1'b0;
      field_p   <= 1'b0;
      up_p      <= 1'b0;
      down_p    <= 1'b0;
      start_p   <= 1'b0;
      clear_p   <= 1'b0;
      seg_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      en        <= F_NONE;
      aumento   <= 1'b0;
      disminuye <= 1'b0;
      clr_cnt   <= 1'b0;
      running   <= 1'b0;
      full      <= 1'b0;
`ifdef CRONO_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      c_min     <= c_min_nx;
      c_hr      <= c_hr_nx;
      field_q   <= btn_field;
      up_q      <= btn_up;
      down_q    <= btn_down;
      start_q   <= btn_start;
      clear_q   <= btn_clear;
      tick_q    <= tick_1hz;
      field_p   <= field_q;
      up_p      <= up_q;
      down_p    <= down_q;
      start_p   <= start_q;
      clear_p   <= clear_q;
      seg_q     <= seg_val;
      min_q     <= min_val;
      hr_q      <= hr_val;
      en        <= en_nx;
      aumento   <= aumento_nx;
      disminuye <= disminuye_nx;
      clr_cnt   <= clr_nx;
      running   <= running_nx;
      full      <= full_nx;
`ifdef CRONO_AUTOREPEAT_EN
      rep_cnt   <= rep_nx;
`endif
    end
  end

endmodule

// File: tb/tb_crono_ctrl.sv
// Directed bench for crono_ctrl: field edit, carry burst, overflow/clear,
// ignored presses, reset mid-burst and up/down repeat behaviour.
module tb_crono_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_field = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       btn_start = 1'b0, btn_clear = 1'b0, tick_1hz = 1'b0;
  logic [5:0] seg_val = '0, min_val = '0;
  logic [4:0] hr_val = '0;
  logic [1:0] en;
  logic       aumento, disminuye, clr_cnt, running, full;
  int         total = 0;
  int         bad = 0;

  crono_ctrl #(.REP_DELAY(10), .REP_PERIOD(4)) dut (
    .clk(clk), .rst(rst),
    .btn_field(btn_field), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start), .btn_clear(btn_clear), .tick_1hz(tick_1hz),
    .seg_val(seg_val), .min_val(min_val), .hr_val(hr_val),
    .en(en), .aumento(aumento), .disminuye(disminuye), .clr_cnt(clr_cnt),
    .running(running), .full(full)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // 0 field, 1 up, 2 down, 3 start, 4 clear, 5 tick; returns when the response is visible.
  task automatic pulse(input int which);
    case (which)
      0: btn_field = 1'b1;
      1: btn_up    = 1'b1;
      2: btn_down  = 1'b1;
      3: btn_start = 1'b1;
      4: btn_clear = 1'b1;
      default: tick_1hz = 1'b1;
    endcase
    cyc();
    {btn_field, btn_up, btn_down, btn_start, btn_clear, tick_1hz} = '0;
    cyc();
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    total++;
    if ({en, aumento, disminuye, clr_cnt, running, full} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=0", {en, aumento, disminuye, clr_cnt, running, full});
    end
    rst = 1'b1;
    cyc();
    total++;
    if (en !== 2'd2 || running !== 1'b0) begin
      bad++;
      $display("FAIL reset_release en=%0d running=%0d exp en=2 running=0", en, running);
    end
  endtask

  task automatic test_field_edit();
    pulse(0);
    total++;
    if (en !== 2'd1) begin bad++; $display("FAIL field_min en=%0d exp=1", en); end
    pulse(0);
    total++;
    if (en !== 2'd3) begin bad++; $display("FAIL field_hr en=%0d exp=3", en); end
    pulse(1);
    total++;
    if (aumento !== 1'b1 || en !== 2'd3) begin
      bad++;
      $display("FAIL field_up aumento=%0d en=%0d exp aumento=1 en=3", aumento, en);
    end
    cyc();
    total++;
    if (aumento !== 1'b0) begin bad++; $display("FAIL field_up_one aumento=%0d exp=0", aumento); end
  endtask

  task automatic test_full_carry();
    pulse(3);
    total++;
    if (running !== 1'b1 || en !== 2'd0) begin
      bad++;
      $display("FAIL start_run running=%0d en=%0d exp running=1 en=0", running, en);
    end
    seg_val = 6'd59; min_val = 6'd59; hr_val = 5'd4;
    pulse(5);
    total++;
    if (aumento !== 1'b1 || en !== 2'd2) begin
      bad++;
      $display("FAIL carry_seg aumento=%0d en=%0d exp aumento=1 en=2", aumento, en);
    end
    cyc();
    total++;
    if (aumento !== 1'b1 || en !== 2'd1) begin
      bad++;
      $display("FAIL carry_min aumento=%0d en=%0d exp aumento=1 en=1", aumento, en);
    end
    cyc();
    total++;
    if (aumento !== 1'b1 || en !== 2'd3) begin
      bad++;
      $display("FAIL carry_hr aumento=%0d en=%0d exp aumento=1 en=3", aumento, en);
    end
    cyc();
    total++;
    if (aumento !== 1'b0 || en !== 2'd0 || running !== 1'b1) begin
      bad++;
      $display("FAIL carry_done aumento=%0d en=%0d running=%0d exp 0/0/1", aumento, en, running);
    end
  endtask

  task automatic test_overflow_clear();
    seg_val = 6'd59; min_val = 6'd59; hr_val = 5'd23;
    pulse(5);
    total++;
    if (aumento !== 1'b0 || full !== 1'b1 || running !== 1'b0 || en !== 2'd0) begin
      bad++;
      $display("FAIL overflow aumento=%0d full=%0d running=%0d en=%0d exp 0/1/0/0",
               aumento, full, running, en);
    end
    pulse(3);
    total++;
    if (full !== 1'b1 || running !== 1'b0) begin
      bad++;
      $display("FAIL full_holds full=%0d running=%0d exp 1/0", full, running);
    end
    pulse(4);
    total++;
    if (clr_cnt !== 1'b1 || full !== 1'b0 || en !== 2'd2) begin
      bad++;
      $display("FAIL clear clr_cnt=%0d full=%0d en=%0d exp 1/0/2", clr_cnt, full, en);
    end
    cyc();
    total++;
    if (clr_cnt !== 1'b0) begin bad++; $display("FAIL clear_one clr_cnt=%0d exp=0", clr_cnt); end
  endtask

  task automatic test_ignored_presses();
    btn_up = 1'b1; btn_down = 1'b1;
    cyc();
    btn_up = 1'b0; btn_down = 1'b0;
    cyc();
    total++;
    if (aumento !== 1'b0 || disminuye !== 1'b0) begin
      bad++;
      $display("FAIL both_edges aumento=%0d disminuye=%0d exp 0/0", aumento, disminuye);
    end
    pulse(2);
    total++;
    if (disminuye !== 1'b1 || aumento !== 1'b0 || en !== 2'd2) begin
      bad++;
      $display("FAIL down disminuye=%0d aumento=%0d en=%0d exp 1/0/2", disminuye, aumento, en);
    end
    pulse(3);
    pulse(1);
    total++;
    if (aumento !== 1'b0 || en !== 2'd0) begin
      bad++;
      $display("FAIL up_in_run aumento=%0d en=%0d exp 0/0", aumento, en);
    end
    seg_val = 6'd10; min_val = 6'd59; hr_val = 5'd2;
    pulse(5);
    total++;
    if (aumento !== 1'b1 || en !== 2'd2) begin
      bad++;
      $display("FAIL tick_nocarry aumento=%0d en=%0d exp 1/2", aumento, en);
    end
    cyc();
    total++;
    if (aumento !== 1'b0 || en !== 2'd0 || running !== 1'b1) begin
      bad++;
      $display("FAIL nocarry_done aumento=%0d en=%0d running=%0d exp 0/0/1", aumento, en, running);
    end
  endtask

  task automatic test_reset_mid_burst();
    seg_val = 6'd59; min_val = 6'd59; hr_val = 5'd4;
    pulse(5);
    cyc();
    total++;
    if (en !== 2'd1 || aumento !== 1'b1) begin
      bad++;
      $display("FAIL burst_min en=%0d aumento=%0d exp 1/1", en, aumento);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({en, aumento, disminuye, clr_cnt, running, full} !== 7'b0) begin
      bad++;
      $display("FAIL async_reset got=%b exp=0", {en, aumento, disminuye, clr_cnt, running, full});
    end
    cyc();
    rst = 1'b1;
    cyc();
    total++;
    if (en !== 2'd2 || aumento !== 1'b0 || running !== 1'b0) begin
      bad++;
      $display("FAIL after_reset en=%0d aumento=%0d running=%0d exp 2/0/0", en, aumento, running);
    end
    cyc();
    total++;
    if (aumento !== 1'b0 || en !== 2'd2) begin
      bad++;
      $display("FAIL no_inc_hr aumento=%0d en=%0d exp 0/2", aumento, en);
    end
  endtask

  task automatic test_autorepeat();
    logic [31:0] mask;
    logic [31:0] exp_mask;
    int          hits;
    int          exp_hits;
`ifdef CRONO_AUTOREPEAT_EN
    exp_mask = (32'd1 << 1) | (32'd1 << 11) | (32'd1 << 15) | (32'd1 << 19);
    exp_hits = 4;
`else
    exp_mask = 32'd1 << 1;
    exp_hits = 1;
`endif
    mask = '0;
    hits = 0;
    btn_down = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cyc();
      if (disminuye === 1'b1) begin
        mask[k] = 1'b1;
        hits++;
      end
      if (k == 19) btn_down = 1'b0;
    end
    total++;
    if (hits !== exp_hits) begin
      bad++;
      $display("FAIL repeat_count got=%0d exp=%0d", hits, exp_hits);
    end
    total++;
    if (mask !== exp_mask) begin
      bad++;
      $display("FAIL repeat_slots got=%h exp=%h", mask, exp_mask);
    end
  endtask

  initial begin
    test_reset();
    test_field_edit();
    test_full_carry();
    test_overflow_clear();
    test_ignored_presses();
    test_reset_mid_burst();
    test_autorepeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/crono_ctrl.md
# crono_ctrl

Sequencing controller for the stopwatch counter bank (hours, minutes, seconds). It turns debounced push-button levels into single-cycle `aumento`/`disminuye` pulses qualified by the field code on `en`, which is how the user edits the time. In run mode it converts `tick_1hz` into an ordered increment burst seconds→minutes→hours with carry. It sits between the button debouncers and the three counter instances and also drives their shared synchronous clear.

## Interface
- `REP_DELAY`, 50_000_000: hold cycles before the first auto-repeat pulse. Only used when the auto-repeat macro is defined.
- `REP_PERIOD`, 10_000_000: cycles between subsequent auto-repeat pulses.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_field`, `btn_up`, `btn_down`, `btn_start`, `btn_clear`  in  1 each  debounced button levels.
- `tick_1hz`  in  1  one-cycle pulse at 1 Hz.
- `seg_val`  in  6  current seconds counter value.
- `min_val`  in  6  current minutes counter value.
- `hr_val`  in  5  current hours counter value.
- `en`  out  2  field code: 0 = none, 1 = minutes, 2 = seconds, 3 = hours.
- `aumento`  out  1  one-cycle increment strobe for the field on `en`.
- `disminuye`  out  1  one-cycle decrement strobe for the field on `en`.
- `clr_cnt`  out  1  one-cycle synchronous clear to all counters.
- `running`  out  1  high in RUN and INC_* states.
- `full`  out  1  high in FULL.

## Operation
- **Buttons.** Each button is rising-edge detected against a registered copy; all actions use edges, not levels.
- **States.** IDLE, RUN, INC_SEG, INC_MIN, INC_HR, FULL.
- **Field select.** Internal `sel`, reset value seconds. A `btn_field` edge in IDLE cycles seconds→minutes→hours→seconds.
- **IDLE.**
  - `en` = `sel`.
  - `btn_up` edge → `aumento` = 1 for one cycle.
  - `btn_down` edge → `disminuye` = 1 for one cycle.
  - Up and down edges in the same cycle → no pulse.
  - `btn_start` edge → RUN.
- **RUN.**
  - `en` = 0; up, down and field edges are ignored.
  - `btn_start` edge → IDLE.
  - `tick_1hz` with time below 23:59:59 → INC_SEG. The carry flags are latched from the pre-increment values at the tick:
    - `c_min` = (`seg_val` == 59)
    - `c_hr` = `c_min` && (`min_val` == 59)
  - `tick_1hz` at exactly 23:59:59 → FULL, with no strobe issued.
- **Increment burst.**
  - INC_SEG: `en` = 2, `aumento` = 1. Next state is INC_MIN if `c_min`, else RUN.
  - INC_MIN: `en` = 1, `aumento` = 1. Next state is INC_HR if `c_hr`, else RUN.
  - INC_HR: `en` = 3, `aumento` = 1. Next state is RUN.
  - Ticks arriving during INC_* are dropped. The burst takes at most 3 cycles, so no tick is lost at 1 Hz.
- **FULL.** `running` = 0, `full` = 1, `en` = 0. Only clear leaves this state.
- **Clear.** A `btn_clear` edge in any state:
  - `clr_cnt` = 1 for one cycle;
  - state → IDLE; `sel` → seconds; `full` → 0.
- **Priority.** clear > start > field > up/down.

## Timing
- All outputs are registered.
- Reset values: `en` = 0, `aumento` = 0, `disminuye` = 0, `clr_cnt` = 0, `running` = 0, `full` = 0. Internal state: state = IDLE, `sel` = seconds, edge registers = 0.
- Reset assertion clears everything immediately, including mid-burst; a partial carry is not completed.
- After reset release, `en` = 2 from the first clock edge onward.
- Button edge → strobe: the button is sampled high at edge N and the strobe is high from edge N+1 to N+2. The counter updates at edge N+2.
- Tick at edge N → INC_SEG strobe during cycle N+1. INC_MIN follows at N+2, INC_HR at N+3.
- `clr_cnt` and `running`/`full` changes appear one cycle after the sampled edge.

## Configuration
- **`CRONO_AUTOREPEAT_EN` defined.** In IDLE, holding exactly one of `btn_up`/`btn_down` works as follows:
  - the first strobe comes on the edge;
  - after `REP_DELAY` held cycles, a further strobe is issued;
  - further strobes follow every `REP_PERIOD` held cycles.
  - Release, leaving IDLE, or both buttons held resets the repeat counter.
- **Undefined.** Exactly one strobe per press. No repeat counter is synthesized and the parameters are unused.

## Test plan
1. **Field edit.** Release reset; pulse `btn_field` twice, then `btn_up` once → `en` goes 2→1→3; then one cycle of `aumento` = 1 with `en` = 3.
2. **Full carry.** Start with `seg_val` = 59, `min_val` = 59, `hr_val` = 4; pulse `tick_1hz` → consecutive strobes on `en` = 2, 1, 3; then `en` = 0 and `running` = 1.
3. **Overflow and clear.** At 23:59:59 in RUN, pulse tick → no strobe, `full` = 1, `running` = 0. Then `btn_clear` → `clr_cnt` high for 1 cycle, `full` = 0, `en` = 2.
4. **Ignored presses.** Up and down rising in the same cycle in IDLE → no strobe. `btn_up` edge in RUN → no strobe.
5. **Reset mid-burst.** Assert `rst` low during INC_MIN → all outputs 0 without waiting for a clock edge. After release: IDLE, `en` = 2, no INC_HR strobe.
6. **Auto-repeat.** With `CRONO_AUTOREPEAT_EN`, `REP_DELAY` = 10, `REP_PERIOD` = 4, hold `btn_down` for 20 cycles → strobes at relative cycles 1, 11, 15, 19 (4 total). Without the macro → 1 strobe.
